match_ctrl: RTL and testbench

MATCH_CTRL -- requirements
Module: match_ctrl

---
 rtl/match_ctrl_pkg.sv | 28 ++
 rtl/match_ctrl_frame_timer.sv | 37 +++
 rtl/match_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_match_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/match_ctrl_pkg.sv
// Shared match-control types and defaults: state encodings, default match/timing parameters
// and a saturating score helper.
package match_ctrl_pkg;

  localparam int DEF_WIN_SCORE    = 11;
  localparam int DEF_COUNT_FRAMES = 60;
  localparam int DEF_HOLD_FRAMES  = 90;

  localparam int FRAME_CNT_W = 8;
  localparam int SCORE_W     = 4;

  localparam logic [1:0] COUNTDOWN_START = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COUNTDOWN  = 3'd1,
    ST_PLAY       = 3'd2,
    ST_PAUSED     = 3'd3,
    ST_POINT_HOLD = 3'd4,
    ST_MATCH_OVER = 3'd5
  } state_e;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                 input logic [SCORE_W-1:0] lim);
    return (s < lim) ? s + 4'd1 : lim;
  endfunction

endpackage

// File: rtl/match_ctrl_frame_timer.sv
// frame_timer: counts frame pulses up to limit_i; done_o is combinational on the final frame,
// no backpressure. load_i clears the count and takes priority over frame_i.
module match_ctrl_frame_timer
  import match_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic                   frame_i,
  input  logic [FRAME_CNT_W-1:0] limit_i,
  output logic                   done_o
);

  logic [FRAME_CNT_W-1:0] cnt_q;
  logic [FRAME_CNT_W-1:0] cnt_d;

  // done must not depend on load_i: the owner derives load from its own next state
  assign done_o = frame_i && (cnt_q == (limit_i - 8'd1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (frame_i) begin
      cnt_d = done_o ? '0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/match_ctrl.sv
// Match sequencing for a two-player paddle game: countdown, play, pause, point hold, match over.
// All outputs registered (one cycle after the triggering input edge); no backpressure.
module match_ctrl
  import match_ctrl_pkg::*;
#(
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int COUNT_FRAMES = DEF_COUNT_FRAMES,
  parameter int HOLD_FRAMES  = DEF_HOLD_FRAMES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_clk,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic               point_scored,
  input  logic               point_side,
  output logic               start_game,
  output logic               hold,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic [1:0]         countdown,
  output logic               match_over,
  output logic               winner,
  output logic [2:0]         ctrl_state
);

  localparam logic [SCORE_W-1:0]     WIN_L   = SCORE_W'(WIN_SCORE);
  localparam logic [FRAME_CNT_W-1:0] COUNT_L = FRAME_CNT_W'(COUNT_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] HOLD_L  = FRAME_CNT_W'(HOLD_FRAMES);

  state_e             state_q, state_d;
  logic [1:0]         cd_q, cd_d;
  logic [SCORE_W-1:0] sl_q, sl_d;
  logic [SCORE_W-1:0] sr_q, sr_d;
  logic               dir_q, dir_d;
  logic               win_q, win_d;
  logic               sg_q, sg_d;
  logic               hold_q;
  logic               mo_q;
  logic               start_prev_q;
  logic               pause_prev_q;

  logic               start_ev;
  logic               pause_ev;
  logic               timer_load;
  logic               timer_frame;
  logic [FRAME_CNT_W-1:0] timer_limit;
  logic               timer_done;
  logic [SCORE_W-1:0] new_score;

  assign start_ev = btn_start && !start_prev_q;
  assign pause_ev = btn_pause && !pause_prev_q;

  // One shared timer; only the two timed states feed it frames
  assign timer_frame = frame_clk && ((state_q == ST_COUNTDOWN) || (state_q == ST_POINT_HOLD));
  assign timer_limit = (state_q == ST_POINT_HOLD) ? HOLD_L : COUNT_L;
  assign timer_load  = (state_d != state_q);

  match_ctrl_frame_timer u_frame_timer (
    .clk     (clk),
    .rst_n   (reset),
    .load_i  (timer_load),
    .frame_i (timer_frame),
    .limit_i (timer_limit),
    .done_o  (timer_done)
  );

  assign new_score = point_side ? sat_inc(sr_q, WIN_L) : sat_inc(sl_q, WIN_L);

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    dir_d   = dir_q;
    win_d   = win_q;
    sg_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sl_d = '0;
        sr_d = '0;
        if (start_ev) begin
          cd_d    = COUNTDOWN_START;
          dir_d   = 1'b1;
          state_d = ST_COUNTDOWN;
        end
      end
      ST_COUNTDOWN: begin
        if (timer_done) begin
          cd_d = cd_q - 2'd1;
          if (cd_q == 2'd1) begin
            state_d = ST_PLAY;
            sg_d    = 1'b1;
          end
        end
      end
      ST_PLAY: begin
        // A point wins over a simultaneous pause press
        if (point_scored) begin
          if (point_side) begin
            sr_d = new_score;
          end else begin
            sl_d = new_score;
          end
          if (new_score == WIN_L) begin
            win_d   = point_side;
            state_d = ST_MATCH_OVER;
          end else begin
            dir_d   = !point_side;
            state_d = ST_POINT_HOLD;
          end
        end else if (pause_ev) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (pause_ev) begin
          state_d = ST_PLAY;
        end
      end
      ST_POINT_HOLD: begin
        if (timer_done) begin
          cd_d    = COUNTDOWN_START;
          state_d = ST_COUNTDOWN;
        end
      end
      ST_MATCH_OVER: begin
        if (start_ev) begin
          sl_d    = '0;
          sr_d    = '0;
          win_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cd_q         <= '0;
      sl_q         <= '0;
      sr_q         <= '0;
      dir_q        <= 1'b1;
      win_q        <= 1'b0;
      sg_q         <= 1'b0;
      hold_q       <= 1'b1;
      mo_q         <= 1'b0;
      start_prev_q <= 1'b0;
      pause_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cd_q         <= cd_d;
      sl_q         <= sl_d;
      sr_q         <= sr_d;
      dir_q        <= dir_d;
      win_q        <= win_d;
      sg_q         <= sg_d;
      hold_q       <= (state_d != ST_PLAY);
      mo_q         <= (state_d == ST_MATCH_OVER);
      start_prev_q <= btn_start;
      pause_prev_q <= btn_pause;
    end
  end

  assign start_game  = sg_q;
  assign hold        = hold_q;
  assign serve_dir   = dir_q;
  assign score_left  = sl_q;
  assign score_right = sr_q;
  assign countdown   = cd_q;
  assign match_over  = mo_q;
  assign winner      = win_q;
  assign ctrl_state  = state_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl: directed vector table, hand-written corner sequences and random
// stimulus, all checked against a frames-remaining reference model of the match rules.
module tb_match_ctrl;
  import match_ctrl_pkg::*;

  localparam int WIN   = 3;
  localparam int CNTF  = 2;
  localparam int HOLDF = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_clk, btn_start, btn_pause, point_scored, point_side;
  logic       start_game, hold, serve_dir, match_over, winner;
  logic [3:0] score_left, score_right;
  logic [1:0] countdown;
  logic [2:0] ctrl_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  match_ctrl #(.WIN_SCORE(WIN), .COUNT_FRAMES(CNTF), .HOLD_FRAMES(HOLDF)) dut (
    .clk(clk), .reset(reset), .frame_clk(frame_clk), .btn_start(btn_start),
    .btn_pause(btn_pause), .point_scored(point_scored), .point_side(point_side),
    .start_game(start_game), .hold(hold), .serve_dir(serve_dir),
    .score_left(score_left), .score_right(score_right), .countdown(countdown),
    .match_over(match_over), .winner(winner), .ctrl_state(ctrl_state)
  );

  // Reference model: frames_left counts down to the next countdown step / end of hold
  state_e m_state;
  int     m_cd, m_left, m_sl, m_sr;
  bit     m_dir, m_win, m_sg, m_ps, m_pp;

  task automatic model_reset();
    m_state = ST_IDLE; m_cd = 0; m_left = 0; m_sl = 0; m_sr = 0;
    m_dir = 1'b1; m_win = 1'b0; m_sg = 1'b0; m_ps = 1'b0; m_pp = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit pa, input bit fr, input bit pt, input bit sd);
    bit se, pe;
    se = st && !m_ps;
    pe = pa && !m_pp;
    m_ps = st;
    m_pp = pa;
    m_sg = 1'b0;
    case (m_state)
      ST_IDLE: if (se) begin m_cd = 3; m_left = CNTF; m_dir = 1'b1; m_state = ST_COUNTDOWN; end
      ST_COUNTDOWN: if (fr) begin
        m_left--;
        if (m_left == 0) begin
          m_left = CNTF;
          m_cd--;
          if (m_cd == 0) begin m_state = ST_PLAY; m_sg = 1'b1; end
        end
      end
      ST_PLAY: begin
        if (pt) begin
          if (sd) m_sr++; else m_sl++;
          if ((sd ? m_sr : m_sl) == WIN) begin m_state = ST_MATCH_OVER; m_win = sd; end
          else begin m_state = ST_POINT_HOLD; m_left = HOLDF; m_dir = !sd; end
        end else if (pe) m_state = ST_PAUSED;
      end
      ST_PAUSED: if (pe) m_state = ST_PLAY;
      ST_POINT_HOLD: if (fr) begin
        m_left--;
        if (m_left == 0) begin m_state = ST_COUNTDOWN; m_cd = 3; m_left = CNTF; end
      end
      ST_MATCH_OVER: if (se) begin m_sl = 0; m_sr = 0; m_win = 1'b0; m_state = ST_IDLE; end
      default: m_state = ST_IDLE;
    endcase
  endtask

  task automatic check_model();
    logic [17:0] act, exp;
    act = {ctrl_state, countdown, score_left, score_right, hold, start_game, serve_dir,
           match_over, winner};
    exp = {m_state, 2'(m_cd), 4'(m_sl), 4'(m_sr), (m_state != ST_PLAY), m_sg, m_dir,
           (m_state == ST_MATCH_OVER), m_win};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t: got {st,cd,sl,sr,hold,sg,dir,mo,win}=%h required %h",
               $time, act, exp);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit st, input bit pa, input bit fr, input bit pt, input bit sd);
    btn_start = st; btn_pause = pa; frame_clk = fr; point_scored = pt; point_side = sd;
    @(posedge clk);
    model_step(st, pa, fr, pt, sd);
    #1;
    check_model();
  endtask

  task automatic run_to_play();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      seen = start_game;
    end
    chk("run_to_play_start_game_seen", int'(seen), 1);
  endtask

  task automatic do_reset();
    btn_start = 0; btn_pause = 0; frame_clk = 0; point_scored = 0; point_side = 0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", int'(ctrl_state), int'(ST_IDLE));
    chk("reset_outputs", int'({hold, serve_dir, start_game, match_over, winner}), 5'b11000);
    chk("reset_counts", int'({countdown, score_left, score_right}), 0);
    reset = 1'b1;
  endtask

  typedef struct {
    bit st, pa, fr, pt, sd;
    logic [2:0] e_state;
    logic [1:0] e_cd;
    logic [3:0] e_sl, e_sr;
    bit e_hold, e_sg, e_dir;
  } vec_t;

  function automatic vec_t mk(input bit st, input bit pa, input bit fr, input bit pt, input bit sd,
                              input state_e s, input int cd, input int sl, input int sr,
                              input bit h, input bit sg, input bit dir);
    vec_t v;
    v.st = st; v.pa = pa; v.fr = fr; v.pt = pt; v.sd = sd;
    v.e_state = s; v.e_cd = 2'(cd); v.e_sl = 4'(sl); v.e_sr = 4'(sr);
    v.e_hold = h; v.e_sg = sg; v.e_dir = dir;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit rs, rp;
    tbl[0]  = mk(1,0,0,0,0, ST_COUNTDOWN,  3,0,0, 1,0,1);
    tbl[1]  = mk(0,0,1,0,0, ST_COUNTDOWN,  3,0,0, 1,0,1);
    tbl[2]  = mk(0,0,0,0,0, ST_COUNTDOWN,  3,0,0, 1,0,1);
    tbl[3]  = mk(0,0,1,0,0, ST_COUNTDOWN,  2,0,0, 1,0,1);
    tbl[4]  = mk(0,0,1,0,0, ST_COUNTDOWN,  2,0,0, 1,0,1);
    tbl[5]  = mk(0,0,1,0,0, ST_COUNTDOWN,  1,0,0, 1,0,1);
    tbl[6]  = mk(0,0,1,0,0, ST_COUNTDOWN,  1,0,0, 1,0,1);
    tbl[7]  = mk(0,0,1,0,0, ST_PLAY,       0,0,0, 0,1,1);
    tbl[8]  = mk(0,0,0,0,0, ST_PLAY,       0,0,0, 0,0,1);
    tbl[9]  = mk(0,0,0,1,1, ST_POINT_HOLD, 0,0,1, 1,0,0);
    tbl[10] = mk(0,0,1,0,0, ST_POINT_HOLD, 0,0,1, 1,0,0);
    tbl[11] = mk(0,0,1,0,0, ST_COUNTDOWN,  3,0,1, 1,0,0);

    do_reset();

    // Countdown to serve, first point and hold back into countdown
    for (int i = 0; i < 12; i++) begin
      logic [15:0] act, exp;
      step(tbl[i].st, tbl[i].pa, tbl[i].fr, tbl[i].pt, tbl[i].sd);
      act = {ctrl_state, countdown, score_left, score_right, hold, start_game, serve_dir};
      exp = {tbl[i].e_state, tbl[i].e_cd, tbl[i].e_sl, tbl[i].e_sr,
             tbl[i].e_hold, tbl[i].e_sg, tbl[i].e_dir};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL vec%0d: got %h required %h", i, act, exp);
      end
    end

    run_to_play();
    step(0,0,0,0,0);

    // Point and pause press in the same cycle: point taken, no pause
    step(0,1,0,1,0);
    chk("pt_pause_state", int'(ctrl_state), int'(ST_POINT_HOLD));
    chk("pt_pause_score_left", int'(score_left), 1);
    step(0,0,0,0,0);
    run_to_play();

    // Paused: points ignored, second press resumes without a serve
    step(0,1,0,0,0);
    chk("pause_state", int'(ctrl_state), int'(ST_PAUSED));
    chk("pause_hold", int'(hold), 1);
    step(0,0,0,1,1);
    step(0,0,0,1,0);
    chk("paused_scores", int'({score_left, score_right}), 8'h11);
    step(0,1,0,0,0);
    chk("resume_state", int'(ctrl_state), int'(ST_PLAY));
    chk("resume_hold_sg", int'({hold, start_game}), 0);
    step(0,0,0,0,0);

    // Left reaches WIN_SCORE; score saturates; start returns to IDLE
    step(0,0,0,1,0);
    run_to_play();
    step(0,0,0,1,0);
    chk("over_flags", int'({match_over, winner}), 2'b10);
    chk("over_score_left", int'(score_left), 3);
    step(0,0,0,1,0);
    step(0,0,0,1,0);
    chk("over_score_frozen", int'(score_left), 3);
    step(1,0,0,0,0);
    chk("restart_state", int'(ctrl_state), int'(ST_IDLE));
    chk("restart_scores", int'({score_left, score_right, match_over}), 0);
    step(0,0,0,0,0);

    // Asynchronous reset mid-countdown
    step(1,0,0,0,0);
    step(0,0,1,0,0);
    step(0,0,1,0,0);
    chk("pre_reset_countdown", int'(countdown), 2);
    reset = 1'b0;
    #2;
    chk("async_reset_state", int'(ctrl_state), int'(ST_IDLE));
    chk("async_reset_outputs", int'({countdown, hold, start_game}), 3'b010);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(0,0,1,0,0);
      chk("post_reset_no_start_game", int'(start_game), 0);
    end

    // Random stimulus against the model
    do_reset();
    rs = 1'b0; rp = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) rs = !rs;
      if ($urandom_range(0, 9) == 0)  rp = !rp;
      step(rs, rp, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
